// File: rtl/xcoord_centroid_if.sv
// Pixel stream into xcoord_centroid: RGB AXI4-Stream with start-of-frame
// (TUSER) and end-of-line (TLAST) markers.
interface xcoord_centroid_if;
    logic [23:0] S_AXIS_TDATA;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TREADY;
    logic        S_AXIS_TUSER;
    logic        S_AXIS_TLAST;

    modport master (
        output S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TUSER, S_AXIS_TLAST,
        input  S_AXIS_TREADY
    );

    modport slave (
        input  S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TUSER, S_AXIS_TLAST,
        output S_AXIS_TREADY
    );
endinterface

// File: rtl/xcoord_centroid.sv
// xcoord_centroid: thresholds an RGB pixel stream, accumulates column sum and
// matched-pixel count per frame, and at end of frame divides them (restoring
// divider, one quotient bit per cycle) to get the mean x-coordinate. The
// result is handed to the downstream DMA with a one-cycle start pulse; the
// block then waits for the DMA's done before taking another result.
//
// Build option: define XCOORD_ROUND_EN for a round-half-up mean
// (dividend = sum + cnt/2); otherwise the mean is truncated.
module xcoord_centroid #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int SUM_W      = 28,
    parameter int CNT_W      = 19
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    xcoord_centroid_if.slave     s_axis,
    input  logic [7:0]           R_MIN,
    input  logic [7:0]           G_MAX,
    input  logic [7:0]           B_MAX,
    output logic [15:0]          XCOORD,
    output logic [CNT_W-1:0]     PIX_COUNT,
    output logic                 FOUND,
    output logic                 COORD_VALID,
    output logic                 M00_AXI_INIT_AXI_TXN,
    input  logic                 M00_AXI_TXN_DONE,
    output logic                 OVERRUN
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int IW = $clog2(SUM_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic             tready_q;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic             armed_q;
    logic [SUM_W-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;

    // divider state
    logic [SUM_W-1:0] dvd_q;
    logic [CNT_W-1:0] dsr_q;
    logic [CNT_W-1:0] rem_q;
    logic [14:0]      quo_q;
    logic [IW-1:0]    it_q;
    logic             zero_q;

    // ---------------------------------------------------------------
    // Beat decode and accumulator next values
    // ---------------------------------------------------------------
    logic             beat, sof, match, hit, eof, eof_take, armed_now;
    logic [XW-1:0]    cur_x;
    logic [YW-1:0]    cur_y;
    logic [SUM_W-1:0] sum_new, dividend;
    logic [CNT_W-1:0] cnt_new;

    assign s_axis.S_AXIS_TREADY = tready_q;

    assign beat  = s_axis.S_AXIS_TVALID && tready_q;
    assign sof   = beat && s_axis.S_AXIS_TUSER;
    assign match = (s_axis.S_AXIS_TDATA[23:16] >= R_MIN) &&
                   (s_axis.S_AXIS_TDATA[15:8]  <= G_MAX) &&
                   (s_axis.S_AXIS_TDATA[7:0]   <= B_MAX);

    // a start-of-frame beat is itself column 0 / row 0
    assign cur_x     = sof ? '0 : x_q;
    assign cur_y     = sof ? '0 : y_q;
    // nothing is counted until a start-of-frame has been seen since reset
    assign armed_now = armed_q || sof;
    assign hit       = beat && armed_now && match;
    assign eof       = beat && s_axis.S_AXIS_TLAST && (cur_y == YW'(IMG_HEIGHT - 1));
    assign eof_take  = eof && armed_now;

    // SOF discards any partial frame: restart from this beat alone
    assign sum_new = (sof ? '0 : sum_q) + (hit ? SUM_W'(cur_x) : '0);
    assign cnt_new = (sof ? '0 : cnt_q) + CNT_W'(hit);

`ifdef XCOORD_ROUND_EN
    assign dividend = sum_new + SUM_W'(cnt_new >> 1);
`else
    assign dividend = sum_new;
`endif

    // ---------------------------------------------------------------
    // Restoring divider step (combinational part)
    // ---------------------------------------------------------------
    logic [CNT_W:0]   rem_sh;
    logic             ge;
    logic [CNT_W-1:0] rem_nx;
    logic [15:0]      quo_nx;
    logic             div_last;

    assign rem_sh   = {rem_q, dvd_q[SUM_W-1]};
    assign ge       = rem_sh >= {1'b0, dsr_q};
    // rem_sh < 2*dsr, so the difference always fits CNT_W bits
    assign rem_nx   = ge ? (rem_sh[CNT_W-1:0] - dsr_q) : rem_sh[CNT_W-1:0];
    // only the low 16 quotient bits are ever reported
    assign quo_nx   = {quo_q, ge};
    assign div_last = zero_q || (it_q == IW'(SUM_W - 1));

    // TREADY low in reset, high from the first clock after release
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) tready_q <= 1'b0;
        else          tready_q <= 1'b1;
    end

    // Column/row position and per-frame accumulators
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            x_q     <= '0;
            y_q     <= '0;
            armed_q <= 1'b0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else if (beat) begin
            if (s_axis.S_AXIS_TLAST) begin
                x_q <= '0;
                y_q <= (cur_y == YW'(IMG_HEIGHT - 1)) ? '0 : cur_y + YW'(1);
            end else begin
                x_q <= cur_x + XW'(1);
                y_q <= cur_y;
            end
            if (sof) armed_q <= 1'b1;
            if (eof_take) begin
                sum_q <= '0;
                cnt_q <= '0;
            end else begin
                sum_q <= sum_new;
                cnt_q <= cnt_new;
            end
        end
    end

    // FSM state register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state and handshake pulses
    always_comb begin
        state_d              = state_q;
        COORD_VALID          = 1'b0;
        M00_AXI_INIT_AXI_TXN = 1'b0;
        case (state_q)
            S_IDLE: if (eof_take) state_d = S_DIV;
            S_DIV:  if (div_last) state_d = S_DONE;
            S_DONE: begin
                COORD_VALID          = 1'b1;
                M00_AXI_INIT_AXI_TXN = 1'b1;
                state_d              = S_WAIT;
            end
            S_WAIT: if (M00_AXI_TXN_DONE) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Divider: load at EOF, then one quotient bit per DIV cycle, MSB first
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            dvd_q  <= '0;
            dsr_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            it_q   <= '0;
            zero_q <= 1'b0;
        end else if (state_q == S_IDLE && eof_take) begin
            dvd_q  <= dividend;
            dsr_q  <= cnt_new;
            rem_q  <= '0;
            quo_q  <= '0;
            it_q   <= '0;
            zero_q <= (cnt_new == '0);
        end else if (state_q == S_DIV && !zero_q) begin
            dvd_q <= {dvd_q[SUM_W-2:0], 1'b0};
            rem_q <= rem_nx;
            quo_q <= quo_nx[14:0];
            it_q  <= it_q + IW'(1);
        end
    end

    // Result registers, updated as the divider finishes
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            XCOORD    <= 16'hFFFF;
            PIX_COUNT <= '0;
            FOUND     <= 1'b0;
        end else if (state_q == S_DIV && div_last) begin
            XCOORD    <= zero_q ? 16'hFFFF : quo_nx;
            PIX_COUNT <= zero_q ? '0 : dsr_q;
            FOUND     <= !zero_q;
        end
    end

    // Sticky overrun: an EOF arrived while a previous result was in flight
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)                         OVERRUN <= 1'b0;
        else if (eof_take && state_q != S_IDLE) OVERRUN <= 1'b1;
    end
endmodule

// File: tb/tb_xcoord_centroid.sv
// Bench for xcoord_centroid on an 8x4 image: directed frames with literal
// expectations plus randomized frames against a frame-level reference model.
module tb_xcoord_centroid;
    localparam int W = 8, H = 4, SUM_W = 28, CNT_W = 19;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b1;
    always #5 ACLK = ~ACLK;

    xcoord_centroid_if axis();
    logic [7:0]       r_min, g_max, b_max;
    logic [15:0]      XCOORD;
    logic [CNT_W-1:0] PIX_COUNT;
    logic             FOUND, COORD_VALID, INIT, done, OVERRUN;

    xcoord_centroid #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .s_axis(axis),
        .R_MIN(r_min), .G_MAX(g_max), .B_MAX(b_max),
        .XCOORD(XCOORD), .PIX_COUNT(PIX_COUNT), .FOUND(FOUND),
        .COORD_VALID(COORD_VALID), .M00_AXI_INIT_AXI_TXN(INIT),
        .M00_AXI_TXN_DONE(done), .OVERRUN(OVERRUN)
    );

    // stimulus side information: column of the current beat, EOF flag
    int sb_x;
    bit sb_eof;

    // ---------------- reference model (frame level) ----------------
    int ecnt;
    bit rdy, armed, mbusy, mov, mm;
    int msum, mcnt, mp, meof, pend_x, pend_cnt;
    longint dvd;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdy = 0; armed = 0; mbusy = 0; mov = 0; msum = 0; mcnt = 0;
        end else begin
            ecnt++;
            if (axis.S_AXIS_TVALID && rdy) begin
                mm = (axis.S_AXIS_TDATA[23:16] >= r_min) && (axis.S_AXIS_TDATA[15:8] <= g_max)
                     && (axis.S_AXIS_TDATA[7:0] <= b_max);
                if (axis.S_AXIS_TUSER) begin armed = 1; msum = 0; mcnt = 0; end
                if (armed && mm) begin msum += sb_x; mcnt++; end
                if (armed && sb_eof) begin
                    if (!mbusy) begin
`ifdef XCOORD_ROUND_EN
                        dvd = msum + (mcnt / 2);
`else
                        dvd = msum;
`endif
                        mbusy    = 1;
                        meof     = ecnt;
                        mp       = ecnt + ((mcnt == 0) ? 1 : SUM_W);
                        pend_cnt = mcnt;
                        pend_x   = (mcnt == 0) ? 'hFFFF : int'((dvd / mcnt) & 'hFFFF);
                    end else begin
                        mov = 1;
                    end
                    msum = 0; mcnt = 0;
                end
            end
            if (mbusy && done && ecnt >= mp + 2) mbusy = 0;
            rdy = 1;
        end
    end

    // ---------------- compare process ----------------
    int ntot = 0, npass = 0;
    int rep_x = 'hFFFF, rep_cnt = 0;
    bit rep_found = 0, exp_p;
    int pin_id = 0, pin_seen = 0, pin_x, pin_cnt, pin_lat;
    int pin_ovr = 0, ovr_seen = 0, pin_ovr_x;

    task automatic chk(input string nm, input longint act, input longint exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            chk("rst_tready", axis.S_AXIS_TREADY, 0);
            chk("rst_xcoord", XCOORD, 'hFFFF);
            chk("rst_count", PIX_COUNT, 0);
            chk("rst_found", FOUND, 0);
            chk("rst_valid", COORD_VALID, 0);
            chk("rst_init", INIT, 0);
            chk("rst_overrun", OVERRUN, 0);
            rep_x = 'hFFFF; rep_cnt = 0; rep_found = 0;
        end else begin
            exp_p = mbusy && (ecnt == mp);
            if (exp_p) begin
                rep_x = pend_x; rep_cnt = pend_cnt; rep_found = (pend_cnt != 0);
                if (pin_id != pin_seen) begin
                    chk("pin_xcoord", XCOORD, pin_x);
                    chk("pin_count", PIX_COUNT, pin_cnt);
                    chk("pin_latency", ecnt - meof, pin_lat);
                    pin_seen = pin_id;
                end
            end
            chk("coord_valid", COORD_VALID, exp_p);
            chk("init_txn", INIT, exp_p);
            chk("xcoord", XCOORD, rep_x);
            chk("pix_count", PIX_COUNT, rep_cnt);
            chk("found", FOUND, rep_found);
            chk("overrun", OVERRUN, mov);
            chk("tready", axis.S_AXIS_TREADY, rdy);
            if (pin_ovr != ovr_seen) begin
                chk("pin_overrun", OVERRUN, 1);
                chk("pin_ovr_xcoord", XCOORD, pin_ovr_x);
                ovr_seen = pin_ovr;
            end
        end
    end

    // ---------------- stimulus ----------------
    int gap_pct = 0;

    task automatic tick();
        @(posedge ACLK); #1;
    endtask

    task automatic idle();
        axis.S_AXIS_TVALID = 0; axis.S_AXIS_TUSER = 0; axis.S_AXIS_TLAST = 0; sb_eof = 0;
    endtask

    // mode 0: all match, 1: none, 2: x=2,5 on row 1, 3: column 6, 4: random
    task automatic send_frame(input int mode, input int stop_after);
        int n = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (n == stop_after) begin idle(); return; end
                while ($urandom_range(99) < gap_pct) begin
                    idle();
                    if (mode == 4) done = ($urandom_range(7) == 0);
                    tick();
                end
                done = (mode == 4) ? ($urandom_range(7) == 0) : 1'b0;
                r_min = 8'h80; g_max = 8'h40; b_max = 8'h40;
                case (mode)
                    0: axis.S_AXIS_TDATA = 24'hFF0000;
                    1: axis.S_AXIS_TDATA = 24'h00FFFF;
                    2: axis.S_AXIS_TDATA = (y == 1 && (x == 2 || x == 5)) ? 24'hFF0000 : 24'h10FF00;
                    3: axis.S_AXIS_TDATA = (x == 6) ? 24'hC02010 : 24'h7F0000;
                    default: begin
                        axis.S_AXIS_TDATA = 24'($urandom);
                        r_min = 8'($urandom); g_max = 8'($urandom); b_max = 8'($urandom);
                    end
                endcase
                axis.S_AXIS_TVALID = 1;
                axis.S_AXIS_TUSER  = (x == 0 && y == 0);
                axis.S_AXIS_TLAST  = (x == W - 1);
                sb_x   = x;
                sb_eof = (x == W - 1 && y == H - 1);
                tick();
                n++;
            end
        end
        idle();
        done = 0;
    endtask

    // DMA responder: random done until the model has gone back to IDLE
    task automatic dma_ack();
        for (int i = 0; i < 400 && mbusy; i++) begin
            done = ($urandom_range(3) == 0);
            tick();
        end
        done = 0;
    endtask

    task automatic pin(input int x, input int c, input int lat);
        pin_x = x; pin_cnt = c; pin_lat = lat; pin_id++;
    endtask

    initial begin
        idle();
        done = 0; sb_x = 0; r_min = 8'h80; g_max = 8'h40; b_max = 8'h40;
        axis.S_AXIS_TDATA = '0;
        #1 ARESETN = 0;
        repeat (3) tick();
        ARESETN = 1;
        repeat (2) tick();

        // all pixels match: sum 112, cnt 32
`ifdef XCOORD_ROUND_EN
        pin(4, 32, SUM_W);
`else
        pin(3, 32, SUM_W);
`endif
        send_frame(0, -1);
        dma_ack();

        // nothing matches: short path
        pin('hFFFF, 0, 1);
        send_frame(1, -1);
        dma_ack();

        // x=2 and x=5 on row 1: sum 7, cnt 2
`ifdef XCOORD_ROUND_EN
        pin(4, 2, SUM_W);
`else
        pin(3, 2, SUM_W);
`endif
        gap_pct = 20;
        send_frame(2, -1);
        dma_ack();

        // SOF mid-frame after 10 matches, then clean frame with column 6
        send_frame(0, 10);
        pin(6, 4, SUM_W);
        send_frame(3, -1);
        dma_ack();

        // second EOF while waiting on the DMA
        pin(6, 4, SUM_W);
        send_frame(3, -1);
        for (int i = 0; i < 100 && !(mbusy && ecnt >= mp + 2); i++) tick();
        send_frame(0, -1);
        tick();
        pin_ovr_x = 6; pin_ovr++;
        tick();
        dma_ack();

        // reset in the middle of the divide
        send_frame(0, -1);
        repeat (10) tick();
        ARESETN = 0;
        repeat (3) tick();
        ARESETN = 1;
        repeat (2) tick();
`ifdef XCOORD_ROUND_EN
        pin(4, 32, SUM_W);
`else
        pin(3, 32, SUM_W);
`endif
        send_frame(0, -1);
        dma_ack();

        // randomized frames, thresholds, gaps and DMA timing
        gap_pct = 30;
        for (int f = 0; f < 16; f++) begin
            send_frame(4, ($urandom_range(7) == 0) ? int'($urandom_range(20)) : -1);
            if ($urandom_range(3) != 0) dma_ack();
        end
        dma_ack();

        idle();
        repeat (5) tick();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
